// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the 32x32 register file.
// Producer A (main pipeline) has fixed priority and is never stalled. Producer B
// (mul/div/load) is decoupled through a DEPTH-entry FIFO. A later A write to a
// register cancels older queued B writes to that register. Per-register busy
// flags let decode stall on registers whose writes are still in flight.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     a_valid,
  input  logic [AW-1:0]            a_waddr,
  input  logic [DW-1:0]            a_wdata,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_waddr,
  input  logic [DW-1:0]            b_wdata,
  output logic                     rf_ena,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            q_raddr1,
  input  logic [AW-1:0]            q_raddr2,
  output logic                     q_busy1,
  output logic                     q_busy2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage: one live bit per slot, plus address and data payload.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic a_wr;
  logic push;
  logic pop;
  logic head_live;

  // Ready depends only on the registered count. A pop in the same cycle does not free a slot early.
  assign b_ready    = (count_q != CW'(DEPTH));
  assign fifo_count = count_q;

  // Writes to register 0 are discarded on both sides.
  assign a_wr      = a_valid && (a_waddr != '0);
  assign push      = b_valid && b_ready && (b_waddr != '0);
  assign pop       = !a_wr && (count_q != '0);
  assign head_live = valid_q[rptr_q];

  // Next-state for the FIFO bookkeeping: cancel, pop, push, count.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // An A write is younger than everything already queued, so older B writes to the same register die.
    if (a_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == a_waddr) valid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PW'(1);
    end
    // Push comes after the cancel loop: a B entry arriving alongside the A write is younger and survives.
    if (push) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!resetn) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO payload write on push.
  always_ff @(posedge clk) begin
    // NOTE: the payload is not reset. The cleared valid bits make stale contents unobservable.
    if (push) begin
      addr_q[wptr_q] <= b_waddr;
      data_q[wptr_q] <= b_wdata;
    end
  end

  // Registered write port. A has priority, then the FIFO head. Address and data hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_ena   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (a_wr) begin
      rf_ena   <= 1'b1;
      rf_waddr <= a_waddr;
      rf_wdata <= a_wdata;
    end else if (pop) begin
      rf_ena <= head_live;
      if (head_live) begin
        rf_waddr <= addr_q[rptr_q];
        rf_wdata <= data_q[rptr_q];
      end
    end else begin
      rf_ena <= 1'b0;
    end
  end

  // A register is busy while a live queued write or the write in the output stage targets it.
  function automatic logic busy_for(input logic [AW-1:0] raddr);
    logic hit;
    hit = rf_ena && (rf_waddr == raddr);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == raddr)) hit = 1'b1;
    end
    return hit && (raddr != '0);
  endfunction

  // Decode-side busy lookups.
  always_comb begin
    q_busy1 = busy_for(q_raddr1);
    q_busy2 = busy_for(q_raddr2);
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter.
// The reference model is a queue of pending B writes plus the expected write-port state.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          a_valid, b_valid, b_ready;
  logic [AW-1:0] a_waddr, b_waddr, rf_waddr, q_raddr1, q_raddr2;
  logic [DW-1:0] a_wdata, b_wdata, rf_wdata;
  logic          rf_ena, q_busy1, q_busy2;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .a_valid    (a_valid),
    .a_waddr    (a_waddr),
    .a_wdata    (a_wdata),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_waddr    (b_waddr),
    .b_wdata    (b_wdata),
    .rf_ena     (rf_ena),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .q_raddr1   (q_raddr1),
    .q_raddr2   (q_raddr2),
    .q_busy1    (q_busy1),
    .q_busy2    (q_busy2),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  bit            m_ena;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    if (m_ena && m_waddr == r) return 1'b1;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ena   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // One clock cycle: drive at negedge, check the combinational outputs, advance the model, check registers.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    bit   rdy;
    bit   push;
    ent_t h;
    @(negedge clk);
    a_valid = av;  a_waddr = aa;  a_wdata = ad;
    b_valid = bv;  b_waddr = ba;  b_wdata = bd;
    q_raddr1 = q1; q_raddr2 = q2;
    #1;
    rdy = (mq.size() != DEPTH);
    check("b_ready", 64'(b_ready), 64'(rdy));
    check("q_busy1", 64'(q_busy1), 64'(m_busy(q1)));
    check("q_busy2", 64'(q_busy2), 64'(m_busy(q2)));
    push = bv && rdy && (ba != 0);
    if (av && aa != 0) begin
      m_ena = 1'b1; m_waddr = aa; m_wdata = ad;
      foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      m_ena = h.live;
      if (h.live) begin
        m_waddr = h.addr;
        m_wdata = h.data;
      end
    end else begin
      m_ena = 1'b0;
    end
    if (push) mq.push_back('{ba, bd, 1'b1});
    @(posedge clk);
    #1;
    check("rf_ena",     64'(rf_ena),     64'(m_ena));
    check("rf_waddr",   64'(rf_waddr),   64'(m_waddr));
    check("rf_wdata",   64'(rf_wdata),   64'(m_wdata));
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
  endtask

  task automatic idle(input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    step(1'b0, '0, '0, 1'b0, '0, '0, q1, q2);
  endtask

  initial begin
    a_valid = 0; a_waddr = 0; a_wdata = 0;
    b_valid = 0; b_waddr = 0; b_wdata = 0;
    q_raddr1 = 0; q_raddr2 = 0;
    resetn = 1'b0;
    model_reset();
    #12;
    check("rst_rf_ena",   64'(rf_ena),     64'd0);
    check("rst_rf_waddr", 64'(rf_waddr),   64'd0);
    check("rst_rf_wdata", 64'(rf_wdata),   64'd0);
    check("rst_count",    64'(fifo_count), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_b_ready", 64'(b_ready), 64'd1);

    // Single A write, visible for one cycle, busy while in the output stage.
    step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd6);
    idle(5'd5, 5'd0);

    // Fill the FIFO while A holds priority on r7, attempt one push while full, then drain.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'd7, 32'h700 + 32'(i), 1'b1, 5'(i), 32'hB00 + 32'(i), 5'(i), 5'd7);
    step(1'b1, 5'd7, 32'h7FF, 1'b1, 5'd5, 32'hDEAD, 5'd4, 5'd5);
    for (int i = 1; i <= 4; i++) idle(5'(i), 5'd7);
    idle(5'd4, 5'd1);

    // Cancellation of a queued write by a younger A write, followed by the drain of the dead slot.
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd0);
    step(1'b1, 5'd9, 32'hBB, 1'b0, '0, '0, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    idle(5'd9, 5'd0);
    // A and B to the same register in one cycle: the B entry is younger and survives.
    step(1'b1, 5'd9, 32'hCC, 1'b1, 5'd9, 32'hDD, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    idle(5'd9, 5'd0);

    // Register 0 on both producers is dropped.
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Reset in the middle of operation with three queued entries.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd7, 32'h77, 1'b1, 5'd10 + 5'(i), 32'hC0 + 32'(i), 5'd10, 5'd0);
    @(negedge clk);
    a_valid = 0; b_valid = 0; q_raddr1 = 5'd10; q_raddr2 = 5'd11;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("mrst_rf_ena",  64'(rf_ena),     64'd0);
    check("mrst_count",   64'(fifo_count), 64'd0);
    check("mrst_b_ready", 64'(b_ready),    64'd1);
    check("mrst_busy1",   64'(q_busy1),    64'd0);
    check("mrst_busy2",   64'(q_busy2),    64'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(5'd10, 5'd11);

    // Randomised traffic over a small address range for collisions and pointer wrap-around.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < DEPTH + 2; n++) idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
